// File: rtl/divider_sequential.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient to LO and remainder to HI, with Busy/Done handshake for the ALU stall.
module divider_sequential #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, q_q;
  logic             signed_q, negq_q, negr_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, divzero_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag, r_d, q_d, quot_fix, rem_fix;
  logic [WIDTH:0]   shifted, trial;

  always_comb begin
    a_neg    = signed_q & a_q[WIDTH-1];
    b_neg    = signed_q & b_q[WIDTH-1];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    div_zero = (b_q == '0);
    // Partial remainder stays below |B|, so the shifted value never loses its top bit on a failed trial.
    shifted  = {r_q, q_q[WIDTH-1]};
    trial    = shifted - {1'b0, b_mag};
    r_d      = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_d      = {q_q[WIDTH-2:0], ~trial[WIDTH]};
    quot_fix = negq_q ? -q_q : q_q;
    rem_fix  = negr_q ? -r_q : r_q;
  end

  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      signed_q  <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            a_q      <= A;
            b_q      <= B;
            signed_q <= Signed;
            busy_q   <= 1'b1;
            state_q  <= PREP;
          end
        end
        PREP: begin
          q_q     <= a_mag;
          r_q     <= '0;
          negq_q  <= a_neg ^ b_neg;
          negr_q  <= a_neg;
          cnt_q   <= CNT_INIT;
          state_q <= ITER;
        end
        ITER: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) state_q <= FIX;
        end
        FIX: begin
          // Divide-by-zero reports the raw dividend and skips the sign correction.
          if (div_zero) begin
            quot_q    <= '1;
            rem_q     <= a_q;
            divzero_q <= 1'b1;
          end else begin
            quot_q    <= quot_fix;
            rem_q     <= rem_fix;
            divzero_q <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign DivZero   = divzero_q;

endmodule

// File: tb/tb_divider_sequential.sv
// Scoreboard bench for divider_sequential: directed vectors push expected results,
// a negedge monitor pops and checks whenever Done is seen.
module tb_divider_sequential;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         Clear = 1'b0;
  logic         Start = 1'b0;
  logic         Signed = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy, Done, DivZero;
  logic [W-1:0] Quotient, Remainder;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           k;
  } exp_t;

  exp_t sb[$];

  divider_sequential #(.WIDTH(W)) dut (
    .CLK(CLK), .Clear(Clear), .Start(Start), .Signed(Signed), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Quotient(Quotient), .Remainder(Remainder), .DivZero(DivZero)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: Done sampled on the falling edge, edge index k + W + 2 expected.
  always @(negedge CLK) begin
    exp_t e;
    if (Clear && Done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected no pending operation (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        $display("done  cycle=%0d Q=0x%08h R=0x%08h DZ=%0d", cyc, Quotient, Remainder, DivZero);
        check("quotient", Quotient, e.q);
        check("remainder", Remainder, e.r);
        check("divzero", {31'b0, DivZero}, {31'b0, e.dz});
        check("latency", 32'(cyc), 32'(e.k + W + 2));
        check("busy_low_at_done", {31'b0, Busy}, 32'd0);
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no Done within %0d cycles expected Done", n);
      sb.delete();
    end
    @(negedge CLK);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    @(negedge CLK);
    A = a; B = b; Signed = s; Start = 1'b1;
    sb.push_back('{q: eq, r: er, dz: edz, k: cyc + 1});
    $display("issue cycle=%0d A=0x%08h B=0x%08h S=%0d", cyc + 1, a, b, s);
    @(negedge CLK);
    Start = 1'b0;
    check("busy_after_start", {31'b0, Busy}, 32'd1);
    wait_drain();
  endtask

  initial begin
    int k;
    int n;
    repeat (3) @(negedge CLK);
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_done", {31'b0, Done}, 32'd0);
    check("reset_quotient", Quotient, 32'd0);
    check("reset_remainder", Remainder, 32'd0);
    check("reset_divzero", {31'b0, DivZero}, 32'd0);
    Clear = 1'b1;

    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    issue(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
    issue(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0);
    issue(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF, 1'b0);
    issue(32'h80000000, 32'd3, 1'b0, 32'h2AAAAAAA, 32'd2, 1'b0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 1'b0);
    issue(32'd3, 32'd5, 1'b0, 32'd0, 32'd3, 1'b0);
    issue(32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1);
    issue(32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd5, 1'b1);
    issue(32'hFFFFFFF8, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF8, 1'b1);

    // Start while busy is ignored; a Start on the edge ending Done is accepted.
    @(negedge CLK);
    A = 32'hFFFFFFFF; B = 32'h10; Signed = 1'b0; Start = 1'b1;
    k = cyc + 1;
    sb.push_back('{q: 32'h0FFFFFFF, r: 32'hF, dz: 1'b0, k: k});
    $display("issue cycle=%0d A=0x%08h B=0x%08h S=0", k, A, B);
    @(negedge CLK);
    Start = 1'b0;
    repeat (4) @(negedge CLK);
    A = 32'd1; B = 32'd1; Signed = 1'b1; Start = 1'b1;
    $display("issue cycle=%0d A=0x00000001 B=0x00000001 S=1 (while busy)", cyc + 1);
    @(negedge CLK);
    Start = 1'b0;
    check("busy_mid_op", {31'b0, Busy}, 32'd1);
    check("hold_quotient", Quotient, 32'hFFFFFFFF);
    check("hold_remainder", Remainder, 32'hFFFFFFF8);
    check("hold_divzero", {31'b0, DivZero}, 32'd1);
    n = 0;
    while (!Done && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (Done) begin
      A = 32'd1000; B = 32'd10; Signed = 1'b0; Start = 1'b1;
      sb.push_back('{q: 32'd100, r: 32'd0, dz: 1'b0, k: cyc + 1});
      $display("issue cycle=%0d A=0x%08h B=0x%08h S=0 (back-to-back)", cyc + 1, A, B);
      @(negedge CLK);
      Start = 1'b0;
    end
    wait_drain();

    // Clear mid-operation abandons the divide without a Done.
    @(negedge CLK);
    A = 32'd12345; B = 32'd1; Signed = 1'b0; Start = 1'b1;
    $display("issue cycle=%0d A=0x%08h B=0x%08h S=0 (to be cleared)", cyc + 1, A, B);
    @(negedge CLK);
    Start = 1'b0;
    repeat (10) @(negedge CLK);
    Clear = 1'b0;
    #1;
    check("clear_busy", {31'b0, Busy}, 32'd0);
    check("clear_done", {31'b0, Done}, 32'd0);
    check("clear_quotient", Quotient, 32'd0);
    check("clear_remainder", Remainder, 32'd0);
    check("clear_divzero", {31'b0, DivZero}, 32'd0);
    @(negedge CLK);
    Clear = 1'b1;
    repeat (40) @(negedge CLK);
    issue(32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected $finish");
    $fatal(1, "timeout");
  end

endmodule
